// File: rtl/boid_frame_scheduler.sv
// Frame sequencer for the boid memory: walks every boid through accelerator
// start/wait/write-back once per frame and grants single-cycle host writes between frames.
module boid_frame_scheduler #(
  parameter int NUM_BOIDS = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic                         host_req,
  input  logic [$clog2(NUM_BOIDS)-1:0] host_boid,
  input  logic [5:0]                   host_mask,
  output logic                         host_gnt,
  output logic [$clog2(NUM_BOIDS)-1:0] which_boid,
  output logic [6:0]                   wb_en,
  output logic                         xcel_start,
  input  logic                         xcel_done,
  output logic                         busy,
  output logic                         frame_done,
  output logic [15:0]                  frame_count,
  output logic                         frame_overrun,
  output logic                         timeout_err
);

  localparam int IW = $clog2(NUM_BOIDS);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BOIDS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOST, S_READ, S_START, S_WAIT, S_WB, S_NEXT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [IW-1:0] host_boid_q, host_boid_d;
  logic [6:0]    host_wb_q, host_wb_d;
  logic          overrun_q, overrun_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          timeout_err_q, timeout_err_d;
  logic          start_now;

  // Next-state, pending-frame bookkeeping and counters
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    host_boid_d   = host_boid_q;
    host_wb_d     = host_wb_q;
    overrun_d     = 1'b0;
    frame_count_d = frame_count_q;
    timeout_err_d = timeout_err_q;
    start_now     = (state_q == S_IDLE) && !host_req && (frame_start || pend_q);

    // A start consumes one request; a simultaneous pulse and pending flag leaves one queued
    if (start_now) begin
      pend_d = pend_q & frame_start;
    end else if (frame_start) begin
      if (pend_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_d = 1'b1;
      end
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      S_IDLE: begin
        if (host_req) begin
          state_d     = S_HOST;
          host_boid_d = host_boid;
          host_wb_d   = ((int'(host_boid) < NUM_BOIDS) && (host_mask != 6'd0)) ?
                        {host_mask, 1'b1} : 7'd0;
        end else if (start_now) begin
          idx_d   = '0;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOST:  state_d = S_IDLE;
      S_READ:  state_d = S_START;
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (xcel_done) begin
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_NEXT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB:    state_d = S_NEXT;
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_READ;
        end
      end
      S_DONE: begin
        frame_count_d = frame_count_q + 16'd1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      host_boid_q   <= '0;
      host_wb_q     <= 7'd0;
      overrun_q     <= 1'b0;
      frame_count_q <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      host_boid_q   <= host_boid_d;
      host_wb_q     <= host_wb_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Moore output decode from registered state only
  always_comb begin
    host_gnt      = 1'b0;
    which_boid    = '0;
    wb_en         = 7'd0;
    xcel_start    = 1'b0;
    frame_done    = 1'b0;
    busy          = (state_q != S_IDLE);
    frame_count   = frame_count_q;
    frame_overrun = overrun_q;
    timeout_err   = timeout_err_q;
    case (state_q)
      S_HOST: begin
        host_gnt   = 1'b1;
        which_boid = host_boid_q;
        wb_en      = host_wb_q;
      end
      S_READ:  which_boid = idx_q;
      S_START: begin
        which_boid = idx_q;
        xcel_start = 1'b1;
      end
      S_WAIT:  which_boid = idx_q;
      S_WB: begin
        which_boid = idx_q;
        wb_en      = 7'h7F;
      end
      S_NEXT:  which_boid = idx_q;
      S_DONE:  frame_done = 1'b1;
      default: which_boid = '0;
    endcase
  end

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Randomized self-checking bench: per-cycle frame schedules are rebuilt from
// per-boid accelerator latencies and compared against the scheduler outputs.
module tb_boid_frame_scheduler;

  localparam int NB = 3;
  localparam int TO = 4;
  localparam int IW = $clog2(NB);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic          host_req = 1'b0;
  logic [IW-1:0] host_boid = '0;
  logic [5:0]    host_mask = 6'd0;
  logic          host_gnt;
  logic [IW-1:0] which_boid;
  logic [6:0]    wb_en;
  logic          xcel_start;
  logic          xcel_done = 1'b0;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frame_count;
  logic          frame_overrun;
  logic          timeout_err;

  int  checks = 0;
  int  failures = 0;
  int  lat_plan [NB];
  int  resp_cnt = 0;
  int  exp_frames = 0;
  bit  exp_terr = 1'b0;
  int  ovr_seen = 0;
  bit  hold_host = 1'b0;

  typedef struct {
    int         boid;
    bit         xs;
    logic [6:0] wb;
    bit         fd;
  } cyc_t;

  cyc_t exp_q [$];

  boid_frame_scheduler #(.NUM_BOIDS(NB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .host_req(host_req),
    .host_boid(host_boid), .host_mask(host_mask), .host_gnt(host_gnt),
    .which_boid(which_boid), .wb_en(wb_en), .xcel_start(xcel_start),
    .xcel_done(xcel_done), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .frame_overrun(frame_overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Accelerator model: done pulses lat_plan[boid] cycles into WAIT, never when 0
  always @(negedge clk) begin
    xcel_done = 1'b0;
    if (!reset) begin
      resp_cnt = 0;
    end else begin
      if (resp_cnt > 0) begin
        resp_cnt = resp_cnt - 1;
        if (resp_cnt == 0) xcel_done = 1'b1;
      end
      if (xcel_start) resp_cnt = lat_plan[int'(which_boid)];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic cyc_t mk(input int b, input bit xs, input logic [6:0] wb, input bit fd);
    cyc_t e;
    e.boid = b; e.xs = xs; e.wb = wb; e.fd = fd;
    return e;
  endfunction

  function automatic logic [6:0] host_exp(input int hb, input logic [5:0] m);
    return ((hb < NB) && (m != 6'd0)) ? {m, 1'b1} : 7'd0;
  endfunction

  // Builds the expected cycle list from per-boid costs and checks every frame cycle
  task automatic run_frame(input string name, input bit pulse, input int extra_fs);
    exp_q.delete();
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back(mk(i, 1'b0, 7'd0, 1'b0));
      exp_q.push_back(mk(i, 1'b1, 7'd0, 1'b0));
      if (lat_plan[i] >= 1 && lat_plan[i] <= TO) begin
        for (int w = 0; w < lat_plan[i]; w++) exp_q.push_back(mk(i, 1'b0, 7'd0, 1'b0));
        exp_q.push_back(mk(i, 1'b0, 7'h7F, 1'b0));
      end else begin
        for (int w = 0; w < TO; w++) exp_q.push_back(mk(i, 1'b0, 7'd0, 1'b0));
        exp_terr = 1'b1;
      end
      exp_q.push_back(mk(i, 1'b0, 7'd0, 1'b0));
    end
    exp_q.push_back(mk(0, 1'b0, 7'd0, 1'b1));
    if (pulse) frame_start = 1'b1;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      frame_start = ((c % 2) == 1) && (c < 2 * extra_fs);
      if (hold_host && c == 1) host_req = 1'b1;
      if (frame_overrun) ovr_seen++;
      checks++;
      if (which_boid !== IW'(exp_q[c].boid)) begin
        failures++;
        $display("FAIL %s which_boid cyc%0d got=%0d exp=%0d", name, c, which_boid, exp_q[c].boid);
      end
      checks++;
      if (wb_en !== exp_q[c].wb) begin
        failures++;
        $display("FAIL %s wb_en cyc%0d got=%h exp=%h", name, c, wb_en, exp_q[c].wb);
      end
      checks++;
      if ({xcel_start, frame_done} !== {exp_q[c].xs, exp_q[c].fd}) begin
        failures++;
        $display("FAIL %s start_done cyc%0d got=%b%b exp=%b%b", name, c, xcel_start, frame_done,
                 exp_q[c].xs, exp_q[c].fd);
      end
      checks++;
      if ({busy, host_gnt} !== 2'b10) begin
        failures++;
        $display("FAIL %s busy_gnt cyc%0d got=%b%b exp=10", name, c, busy, host_gnt);
      end
    end
    exp_frames++;
    @(negedge clk);
    if (frame_overrun) ovr_seen++;
    checks++;
    if ({busy, frame_done, wb_en, frame_count, timeout_err} !==
        {1'b0, 1'b0, 7'd0, 16'(exp_frames), exp_terr}) begin
      failures++;
      $display("FAIL %s post_idle got busy=%b fd=%b wb=%h cnt=%0d terr=%b exp cnt=%0d terr=%b",
               name, busy, frame_done, wb_en, frame_count, timeout_err, exp_frames, exp_terr);
    end
  endtask

  task automatic host_write(input string name, input int hb, input logic [5:0] m);
    host_boid = IW'(hb);
    host_mask = m;
    host_req  = 1'b1;
    @(negedge clk);
    checks++;
    if ({host_gnt, which_boid, wb_en} !== {1'b1, IW'(hb), host_exp(hb, m)}) begin
      failures++;
      $display("FAIL %s grant got gnt=%b wb=%0d en=%b exp gnt=1 wb=%0d en=%b",
               name, host_gnt, which_boid, wb_en, hb, host_exp(hb, m));
    end
    host_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({host_gnt, busy, wb_en} !== {1'b0, 1'b0, 7'd0}) begin
      failures++;
      $display("FAIL %s after_grant got gnt=%b busy=%b en=%b exp 0", name, host_gnt, busy, wb_en);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({host_gnt, which_boid, wb_en, xcel_start, busy, frame_done, frame_count,
         frame_overrun, timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset outputs got nonzero busy=%b cnt=%0d", busy, frame_count);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < NB; i++) lat_plan[i] = 1;
    run_frame("basic", 1'b1, 0);
  endtask

  task automatic test_host();
    host_write("host_fixed", 1, 6'b000011);
    host_write("host_invalid", 3, 6'b111111);
    host_write("host_nomask", 0, 6'd0);
    repeat (6) host_write("host_rand", int'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63)));
  endtask

  task automatic test_back_to_back();
    int hb;
    logic [5:0] m;
    hb = int'($urandom_range(0, 3));
    m = 6'($urandom_range(0, 63));
    host_boid = IW'(hb); host_mask = m; host_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({host_gnt, which_boid, wb_en} !== {1'b1, IW'(hb), host_exp(hb, m)}) begin
        failures++;
        $display("FAIL b2b grant%0d got gnt=%b wb=%0d en=%b exp wb=%0d en=%b",
                 k, host_gnt, which_boid, wb_en, hb, host_exp(hb, m));
      end
      hb = int'($urandom_range(0, 3));
      m = 6'($urandom_range(0, 63));
      host_boid = IW'(hb); host_mask = m;
      if (k == 4) host_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({host_gnt, busy, wb_en} !== {1'b0, 1'b0, 7'd0}) begin
        failures++;
        $display("FAIL b2b gap%0d got gnt=%b busy=%b en=%b exp 0", k, host_gnt, busy, wb_en);
      end
    end
  endtask

  task automatic test_host_and_frame();
    for (int i = 0; i < NB; i++) lat_plan[i] = 2;
    ovr_seen = 0;
    host_boid = IW'(2); host_mask = 6'b101010;
    host_req = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    host_req = 1'b0; frame_start = 1'b0;
    checks++;
    if ({host_gnt, which_boid, wb_en} !== {1'b1, IW'(2), 7'b1010101}) begin
      failures++;
      $display("FAIL same_cycle host got gnt=%b wb=%0d en=%b exp gnt=1 wb=2 en=1010101",
               host_gnt, which_boid, wb_en);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle idle busy got=%b exp=0", busy);
    end
    run_frame("same_cycle_frame", 1'b0, 0);
    checks++;
    if (ovr_seen !== 0) begin
      failures++;
      $display("FAIL same_cycle overrun got=%0d exp=0", ovr_seen);
    end
  endtask

  task automatic test_host_while_busy();
    for (int i = 0; i < NB; i++) lat_plan[i] = int'($urandom_range(1, TO));
    host_boid = IW'(0); host_mask = 6'b110000;
    hold_host = 1'b1;
    run_frame("host_busy", 1'b1, 0);
    hold_host = 1'b0;
    @(negedge clk);
    host_req = 1'b0;
    checks++;
    if ({host_gnt, which_boid, wb_en} !== {1'b1, IW'(0), 7'b1100001}) begin
      failures++;
      $display("FAIL host_busy late_grant got gnt=%b wb=%0d en=%b exp gnt=1 wb=0 en=1100001",
               host_gnt, which_boid, wb_en);
    end
    @(negedge clk);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NB; i++) lat_plan[i] = int'($urandom_range(1, TO));
      run_frame("random", 1'b1, 0);
    end
  endtask

  task automatic test_timeout();
    lat_plan[0] = 0;
    for (int i = 1; i < NB; i++) lat_plan[i] = 1;
    run_frame("timeout", 1'b1, 0);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NB; i++)
        lat_plan[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, TO));
      run_frame("timeout_mix", 1'b1, 0);
    end
  endtask

  task automatic test_reset_mid();
    int fd_seen;
    for (int i = 0; i < NB; i++) lat_plan[i] = 0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, xcel_start} !== 2'b10) begin
      failures++;
      $display("FAIL reset_mid in_wait got busy=%b start=%b exp 10", busy, xcel_start);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if ({host_gnt, which_boid, wb_en, xcel_start, busy, frame_done, frame_count,
         frame_overrun, timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_mid outputs got busy=%b cnt=%0d terr=%b exp all 0",
               busy, frame_count, timeout_err);
    end
    exp_frames = 0;
    exp_terr = 1'b0;
    fd_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (frame_done || busy) fd_seen++;
    end
    checks++;
    if (fd_seen !== 0) begin
      failures++;
      $display("FAIL reset_mid activity got=%0d exp=0", fd_seen);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < NB; i++) lat_plan[i] = int'($urandom_range(1, TO));
    ovr_seen = 0;
    run_frame("overrun_first", 1'b1, 3);
    run_frame("overrun_pending", 1'b0, 0);
    checks++;
    if (ovr_seen !== 2) begin
      failures++;
      $display("FAIL overrun pulses got=%0d exp=2", ovr_seen);
    end
    checks++;
    if (frame_count !== 16'd2) begin
      failures++;
      $display("FAIL overrun frame_count got=%0d exp=2", frame_count);
    end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) lat_plan[i] = 1;
    test_reset();
    test_basic_frame();
    test_host();
    test_back_to_back();
    test_host_and_frame();
    test_host_while_busy();
    test_random_frames();
    test_timeout();
    test_reset_mid();
    test_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boid_frame_scheduler.md
# boid_frame_scheduler

Sequencer for the boid accelerator memory. Once per frame it walks every boid index and drives the memory's `which_boid` select. For each boid it starts the accelerator, waits for completion, then issues the write-back enable. Between frames it grants single-cycle host (HPS) writes into the same memory. It sits between the frame-timing logic, the HPS bridge, the boid accelerator and the boid register memory.

## Interface
Parameters:
- `NUM_BOIDS`, 2: number of boids stored in memory. Must be ≥ 2.
- `TIMEOUT`, 255: maximum number of WAIT cycles before the current boid is abandoned.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse requesting a full update pass.
- `host_req` in 1: host write request. Level; held until granted.
- `host_boid` in $clog2(NUM_BOIDS): boid index targeted by the host write.
- `host_mask` in 6: field enables for the host write. Bit order is x, y, vx, vy, vx_acc, vy_acc (bit 0 = x).
- `host_gnt` out 1: one-cycle grant. Host data is written on this cycle.
- `which_boid` out $clog2(NUM_BOIDS): memory/accelerator boid select.
- `wb_en` out 7: memory write enable. Bit 0 = global enable; bits 6:1 = field enables, in `host_mask` order.
- `xcel_start` out 1: one-cycle accelerator start pulse.
- `xcel_done` in 1: accelerator completion. Sampled only in WAIT.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse when a pass completes.
- `frame_count` out 16: number of completed passes. Wraps modulo 2^16.
- `frame_overrun` out 1: one-cycle pulse when a `frame_start` is dropped.
- `timeout_err` out 1: sticky flag, set on any accelerator timeout.

## Operation
States and transitions:
- IDLE:
  - If `host_req`, go to HOST. Host takes priority over a frame start.
  - Else if `frame_start` or `pend`, clear `pend`, set idx=0, go to READ.
- HOST (1 cycle):
  - `host_gnt`=1, `which_boid`=`host_boid`.
  - `wb_en`={`host_mask`,1} if `host_boid`<NUM_BOIDS and `host_mask`≠0; otherwise 0. The grant is still given in the 0 case.
  - Go to IDLE.
- READ (1 cycle):
  - `which_boid`=idx; no writes. This is the memory/accelerator operand settle cycle.
- START (1 cycle):
  - `xcel_start`=1. Clear the timeout counter. Go to WAIT.
- WAIT:
  - If `xcel_done`, go to WB.
  - Else if the counter equals TIMEOUT−1, set `timeout_err` and go to NEXT. Write-back is skipped, so the boid keeps its old state.
  - Else increment the counter.
  - If `xcel_done` arrives in the same cycle as the timeout, done wins.
- WB (1 cycle):
  - `wb_en`=7'h7F: all fields written for boid idx. Go to NEXT.
- NEXT (1 cycle):
  - If idx=NUM_BOIDS−1, go to DONE.
  - Else idx+1 and go to READ.
- DONE (1 cycle):
  - `frame_done`=1, `frame_count`+1. Go to IDLE.

Frame-start and host handling:
- `pend` is a one-deep pending flag.
  - `frame_start` in any non-IDLE state sets `pend`.
  - `frame_start` in IDLE while a host grant is taken also sets `pend`.
  - `frame_start` while `pend` is already set pulses `frame_overrun` and is dropped.
- Host requests arriving while busy wait for IDLE. They are never granted mid-frame.

Output rules:
- `which_boid`=idx in READ/START/WAIT/WB/NEXT, `host_boid` in HOST, 0 in IDLE/DONE.
- `wb_en`=0 in every state except HOST and WB.

Reset (`reset`=0 at a clock edge):
- State goes to IDLE. idx, `pend` and the counter clear.
- All outputs go to 0, including `frame_count` and `timeout_err`.
- A reset mid-frame abandons the pass with no `frame_done`.

## Timing
- All outputs are registered-state decodes (Moore). `xcel_done` is not combinationally passed to any output.
- `frame_start` sampled in IDLE at edge t: READ at t+1, `xcel_start` high during t+2.
- W = number of WAIT cycles (≥1). A boid costs 4+W cycles: READ, START, W×WAIT, WB, NEXT.
- Frame with no timeouts: `frame_done` is asserted NUM_BOIDS·(4+W)+1 cycles after the sampling edge.
- A timed-out boid costs 3+TIMEOUT cycles.
- Host grant: `host_gnt` and `wb_en` are high in the cycle after `host_req` is sampled in IDLE. Back-to-back host writes take 2 cycles each.

## Test plan
- Reset, NUM_BOIDS=2, `xcel_done` 1 cycle after `xcel_start`, one `frame_start` pulse:
  - `which_boid` sequence 0 then 1.
  - Two `xcel_start` pulses; `wb_en`=7'h7F once per boid.
  - `frame_done` 11 cycles after the start edge; `frame_count`=1.
- `host_req` with `host_boid`=1, `host_mask`=6'b000011 in IDLE:
  - Next cycle: `host_gnt`=1, `which_boid`=1, `wb_en`=7'b0000111.
  - Then IDLE.
- `host_req` and `frame_start` in the same IDLE cycle:
  - HOST first, then READ two cycles after the request.
  - No `frame_overrun`.
- `xcel_done` held 0, TIMEOUT=4:
  - `timeout_err` set.
  - No `wb_en` for boid 0; boid 1 still processed.
  - `frame_done` still pulses.
- Three `frame_start` pulses during a busy frame:
  - One `pend`, two `frame_overrun` pulses.
  - The second frame starts immediately after DONE→IDLE.
  - `frame_count`=2.
- `reset` driven 0 during WAIT:
  - Next cycle all outputs are 0.
  - No `frame_done` until a new `frame_start`.
